// File: rtl/pc_redirect_pkg.sv
// pc_redirect_pkg: shared FSM encoding, next-PC select codes and PC increment
package pc_redirect_pkg;
  typedef enum logic [1:0] {RUN = 2'b00, HALT = 2'b01, FAULT = 2'b10} state_t;
  typedef enum logic [1:0] {SEL_INC, SEL_HOLD, SEL_JUMP, SEL_BRANCH} sel_t;
  localparam int PC_INC = 4;
endpackage

// File: rtl/pc_redirect_unit_pc_next_mux.sv
// pc_next_mux: prioritised next-PC (branch > unstalled jump > hold > +4) and alignment check
module pc_next_mux import pc_redirect_pkg::*; #(
  parameter int N_BITS = 32
) (
  input  logic [N_BITS-1:0] pc,
  input  logic              stall,
  input  logic              jump_valid,
  input  logic [N_BITS-1:0] pc_jump,
  input  logic              branch_valid,
  input  logic [N_BITS-1:0] pc_branch,
  output logic [N_BITS-1:0] next_pc,
  output sel_t              sel,
  output logic              misaligned
);
  assign sel = branch_valid ? SEL_BRANCH :
               (jump_valid && !stall) ? SEL_JUMP :
               stall ? SEL_HOLD : SEL_INC;
  assign next_pc = sel == SEL_BRANCH ? pc_branch :
                   sel == SEL_JUMP ? pc_jump :
                   sel == SEL_HOLD ? pc : pc + N_BITS'(PC_INC);
  assign misaligned = (sel == SEL_BRANCH || sel == SEL_JUMP) && next_pc[1:0] != 2'b00;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with RUN/HALT/FAULT control; PC_DEBUG_STEP_EN adds i_step
module pc_redirect_unit import pc_redirect_pkg::*; #(
  parameter int                N_BITS   = 32,
  parameter logic [N_BITS-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_halt,
  input  logic              i_jump_valid,
  input  logic [N_BITS-1:0] i_pc_jump,
  input  logic              i_branch_valid,
  input  logic [N_BITS-1:0] i_pc_branch,
`ifdef PC_DEBUG_STEP_EN
  input  logic              i_step,
`endif
  output logic [N_BITS-1:0] o_pc,
  output logic [N_BITS-1:0] o_pc_4,
  output logic              o_flush_if_id,
  output logic              o_flush_id_ex,
  output logic              o_halted,
  output logic              o_fault
);
  state_t            state, state_nxt;
  logic [N_BITS-1:0] pc, pc_nxt, mux_pc;
  sel_t              sel;
  logic              misaligned, run, step;
`ifdef PC_DEBUG_STEP_EN
  assign step = i_step;
`else
  assign step = 1'b0;
`endif
  assign run = state == RUN;
  // a halt in ID outranks the jump alongside it, so the jump never redirects or flushes
  pc_next_mux #(.N_BITS(N_BITS)) u_mux (
    .pc(pc),
    .stall(i_stall),
    .jump_valid(i_jump_valid && !i_halt),
    .pc_jump(i_pc_jump),
    .branch_valid(i_branch_valid),
    .pc_branch(i_pc_branch),
    .next_pc(mux_pc),
    .sel(sel),
    .misaligned(misaligned)
  );
  always_comb begin
    state_nxt = state;
    pc_nxt = pc;
    if (run) begin
      if (i_halt && !i_branch_valid) state_nxt = HALT;
      else if (misaligned) state_nxt = FAULT;
      else pc_nxt = mux_pc;
    end else if (state == HALT && step) begin
      pc_nxt = pc + N_BITS'(PC_INC);
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= RUN;
      pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
    end
  end
  assign o_pc = pc;
  assign o_pc_4 = pc + N_BITS'(PC_INC);
  assign o_flush_if_id = i_rst_n && run && (sel == SEL_BRANCH || sel == SEL_JUMP);
  assign o_flush_id_ex = i_rst_n && run && sel == SEL_BRANCH;
  assign o_halted = state == HALT;
  assign o_fault = state == FAULT;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed and random stimulus scored against a behavioural PC model
module tb_pc_redirect_unit;
`ifdef PC_DEBUG_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fif;
    logic        fie;
    logic        halted;
    logic        fault;
    int          id;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        jv = 1'b0;
  logic [31:0] pj = '0;
  logic        bv = 1'b0;
  logic [31:0] pb = '0;
  logic        step = 1'b0;
  logic [31:0] o_pc, o_pc_4;
  logic        o_fif, o_fie, o_halted, o_fault;
  exp_t        sb[$];
  logic [31:0] m_pc = '0;
  bit          m_halt = 1'b0;
  bit          m_fault = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          ncyc = 0;
  always #5 clk = ~clk;
  pc_redirect_unit dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_stall(stall),
    .i_halt(halt),
    .i_jump_valid(jv),
    .i_pc_jump(pj),
    .i_branch_valid(bv),
    .i_pc_branch(pb),
`ifdef PC_DEBUG_STEP_EN
    .i_step(step),
`endif
    .o_pc(o_pc),
    .o_pc_4(o_pc_4),
    .o_flush_if_id(o_fif),
    .o_flush_id_ex(o_fie),
    .o_halted(o_halted),
    .o_fault(o_fault)
  );
  task automatic do_cycle(input bit r, input bit s, input bit h, input bit j, input logic [31:0] jt,
                          input bit b, input logic [31:0] bt, input bit st, input bit chk);
    exp_t e;
    bit taken_j;
    logic [31:0] tgt;
    rst_n = r; stall = s; halt = h; jv = j; pj = jt; bv = b; pb = bt; step = st;
    e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.halted = m_halt; e.fault = m_fault;
    e.fif = 1'b0; e.fie = 1'b0; e.id = ncyc;
    if (!r) begin
      m_pc = 32'h0; m_halt = 1'b0; m_fault = 1'b0;
    end else if (!m_halt && !m_fault) begin
      taken_j = j && !s && !h;
      e.fif = b || taken_j;
      e.fie = b;
      if (!b && h) m_halt = 1'b1;
      else begin
        tgt = b ? bt : taken_j ? jt : s ? m_pc : m_pc + 32'd4;
        if ((b || taken_j) && tgt % 4 != 0) m_fault = 1'b1;
        else m_pc = tgt;
      end
    end else if (m_halt && st && STEP_EN) begin
      m_pc = m_pc + 32'd4;
    end
    if (chk) sb.push_back(e);
    ncyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({o_pc, o_pc_4, o_fif, o_fie, o_halted, o_fault} !== {e.pc, e.pc4, e.fif, e.fie, e.halted, e.fault}) begin
        errors++;
        $display("FAIL cycle%0d: got pc=%h pc4=%h fif=%b fie=%b halted=%b fault=%b, expected pc=%h pc4=%h fif=%b fie=%b halted=%b fault=%b",
                 e.id, o_pc, o_pc_4, o_fif, o_fie, o_halted, o_fault, e.pc, e.pc4, e.fif, e.fie, e.halted, e.fault);
      end
    end
  end
  initial begin
    logic [31:0] a, b;
    @(posedge clk);
    #1;
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    do_cycle(1, 0, 0, 1, 32'h400, 0, 0, 0, 1);
    idle(1);
    do_cycle(1, 1, 0, 1, 32'h400, 1, 32'h80, 0, 1);
    idle(1);
    do_cycle(1, 0, 0, 1, 32'h402, 0, 0, 0, 1);
    idle(2);
    do_cycle(1, 0, 0, 1, 32'h100, 0, 0, 0, 1);
    idle(1);
    do_cycle(0, 0, 0, 1, 32'h100, 1, 32'h200, 0, 1);
    idle(1);
    do_cycle(1, 0, 0, 0, 0, 1, 32'h20, 0, 1);
    do_cycle(1, 0, 1, 1, 32'h300, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) do_cycle(1, 0, 0, 1, 32'h500, 1, 32'h600, 0, 1);
    do_cycle(1, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    do_cycle(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) b[1:0] = 2'b00;
      do_cycle($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 2) == 0, a, $urandom_range(0, 3) == 0, b, $urandom_range(0, 3) == 0, 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 Parameter: N_BITS, default 32, datapath/PC width.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 The clock domain SHALL be one clock, and reset SHALL be synchronous and active-low.
REQ-004 Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_stall  in  1  hazard stall: hold PC, suppress ID-stage jump.
- i_halt  in  1  HALT instruction reached ID.
- i_jump_valid  in  1  ID-stage jump taken (J/JAL/JR/JALR).
- i_pc_jump  in  N_BITS  jump target from ID-stage jump logic.
- i_branch_valid  in  1  EX-stage branch taken.
- i_pc_branch  in  N_BITS  branch target.
- o_pc  out  N_BITS  current fetch address.
- o_pc_4  out  N_BITS  o_pc + 4.
- o_flush_if_id  out  1  kill IF/ID contents.
- o_flush_id_ex  out  1  kill ID/EX contents.
- o_halted  out  1  unit in HALT.
- o_fault  out  1  misaligned redirect trapped.

Function
REQ-005 FSM states SHALL be RUN, HALT, FAULT; reset state RUN.
REQ-006 In RUN, next PC priority SHALL be: branch > jump (only when i_stall=0) > hold (i_stall=1) > o_pc+4.
REQ-007 A taken branch SHALL load i_pc_branch next cycle and assert o_flush_if_id and o_flush_id_ex combinationally in that same cycle, even when i_stall=1.
REQ-008 A taken jump SHALL load i_pc_jump next cycle and assert o_flush_if_id only.
REQ-009 Simultaneous branch and jump SHALL take the branch; the jump is discarded (it is younger and is flushed).
REQ-010 Any selected target with bits [1:0]!=0 SHALL NOT load; FSM SHALL move to FAULT, PC held, o_fault=1 from next cycle.
REQ-011 i_halt with no branch in RUN SHALL move to HALT; PC held at its current value; o_halted=1 from next cycle; a simultaneous branch SHALL win and halt is ignored.
REQ-012 In HALT and FAULT, PC SHALL hold, all inputs except reset (and step, REQ-016) SHALL be ignored, flushes SHALL be 0.
REQ-013 o_pc_4 SHALL be o_pc+4, modulo 2^N_BITS (wrap from 32'hFFFF_FFFC to 0 with no fault).
REQ-014 Redirect latency SHALL be exactly one cycle: target visible on o_pc the cycle after valid is sampled.

Reset
REQ-015 With i_rst_n=0 at a rising edge: o_pc=RESET_PC, o_pc_4=RESET_PC+4, state RUN, o_halted=0, o_fault=0, flushes=0 during reset; reset SHALL override every other input, including mid-redirect.

Configuration
REQ-016 Macro PC_DEBUG_STEP_EN: when defined, an input i_step (1 bit) SHALL exist; an i_step pulse in HALT SHALL advance PC by 4 once, then remain in HALT; i_step in RUN/FAULT ignored.
REQ-017 Without PC_DEBUG_STEP_EN: port i_step SHALL be absent; HALT SHALL exit only on reset.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding (RUN=2'b00, HALT=2'b01, FAULT=2'b10) and the PC increment constant 4.
REQ-019 One sub-module, pc_next_mux, SHALL compute the prioritised next-PC and select code; FSM and PC register stay in the top.

Verification
REQ-020 Reset, then 3 idle cycles -> o_pc sequence 0x0,0x4,0x8,0xC; no flushes.
REQ-021 At o_pc=0x10, jump_valid with target 0x400 -> o_flush_if_id=1 that cycle; o_pc=0x400 next; o_flush_id_ex=0.
REQ-022 Same cycle branch 0x80 and jump 0x400, i_stall=1 -> both flushes=1; o_pc=0x80 next.
REQ-023 Jump 0x402 -> o_pc holds, o_fault=1 next cycle; later jump 0x100 ignored; reset -> o_pc=0x0, o_fault=0.
REQ-024 i_halt at o_pc=0x20 -> o_halted=1, o_pc stays 0x20 for 10 cycles; with PC_DEBUG_STEP_EN, one i_step -> o_pc=0x24, still halted.
REQ-025 Load o_pc=0xFFFF_FFFC via branch, idle one cycle -> o_pc=0x0, o_fault=0.
